// File: rtl/mfm_encoder.sv
// Serial MFM encoder: one byte (or A1 sync mark 0x4489) becomes 16 cells, MSB first; a held byte loads one edge after tx_en & hold_full in IDLE.
// Valid/ready with a one-byte holding register; byte_ready is low while it is full, and an empty register at a word boundary inserts gap byte 0x4E.
module mfm_encoder (
   input  logic       clk_10,
   input  logic       reset,
   input  logic [7:0] byte_in,
   input  logic       sync_req,
   input  logic       byte_valid,
   output logic       byte_ready,
   input  logic       tx_en,
   output logic       raw_mfm,
   output logic       busy,
   output logic       underrun
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam logic [15:0] SYNC_WORD = 16'h4489;
   localparam logic [7:0]  GAP_BYTE  = 8'h4E;

   // Clock cell i is set only when data bit i and its predecessor are both 0.
   function automatic logic [15:0] mfm_cells(input logic [7:0] d, input logic prev);
      logic [7:0]  clk_c;
      logic [15:0] cells;
      clk_c = ~({prev, d[7:1]} | d);
      for (int i = 0; i < 8; i++) begin
         cells[2*i+1] = clk_c[i];
         cells[2*i]   = d[i];
      end
      return cells;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  hold_byte_q, hold_byte_d;
   logic        hold_sync_q, hold_sync_d;
   logic        hold_full_q, hold_full_d;
   logic [15:0] cell_sr_q, cell_sr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        prev_d_q, prev_d_d;
   logic        underrun_q, underrun_d;
   logic        byte_ready_q, byte_ready_d;

   logic        accept;
   logic        load_prev;
   logic [15:0] hold_word;
   logic        hold_last;

   always_comb begin
      accept    = byte_valid & byte_ready_q;
      // A word started from IDLE never inherits history from a previous burst.
      load_prev = (state_q == ACTIVE) ? prev_d_q : 1'b0;
      hold_word = hold_sync_q ? SYNC_WORD : mfm_cells(hold_byte_q, load_prev);
      hold_last = hold_sync_q | hold_byte_q[0];
   end

   always_comb begin
      state_d     = state_q;
      hold_byte_d = hold_byte_q;
      hold_sync_d = hold_sync_q;
      hold_full_d = hold_full_q;
      cell_sr_d   = cell_sr_q;
      cnt_d       = cnt_q;
      prev_d_d    = prev_d_q;
      underrun_d  = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d     = 4'd0;
            cell_sr_d = 16'h0000;
            if (tx_en && hold_full_q) begin
               state_d     = ACTIVE;
               cell_sr_d   = hold_word;
               prev_d_d    = hold_last;
               hold_full_d = 1'b0;
            end
         end
         ACTIVE: begin
            cell_sr_d = {cell_sr_q[14:0], 1'b0};
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               if (tx_en && hold_full_q) begin
                  cell_sr_d   = hold_word;
                  prev_d_d    = hold_last;
                  hold_full_d = 1'b0;
               end else if (tx_en) begin
                  cell_sr_d  = mfm_cells(GAP_BYTE, prev_d_q);
                  prev_d_d   = GAP_BYTE[0];
                  underrun_d = 1'b1;
               end else begin
                  state_d   = IDLE;
                  cell_sr_d = 16'h0000;
                  prev_d_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Accept and load are exclusive: byte_ready_q is low whenever hold_full_q is set.
      if (accept) begin
         hold_byte_d = byte_in;
         hold_sync_d = sync_req;
         hold_full_d = 1'b1;
      end

      byte_ready_d = ~hold_full_d;
   end

   always_ff @(posedge clk_10 or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         hold_byte_q  <= 8'h00;
         hold_sync_q  <= 1'b0;
         hold_full_q  <= 1'b0;
         cell_sr_q    <= 16'h0000;
         cnt_q        <= 4'd0;
         prev_d_q     <= 1'b0;
         underrun_q   <= 1'b0;
         byte_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_byte_q  <= hold_byte_d;
         hold_sync_q  <= hold_sync_d;
         hold_full_q  <= hold_full_d;
         cell_sr_q    <= cell_sr_d;
         cnt_q        <= cnt_d;
         prev_d_q     <= prev_d_d;
         underrun_q   <= underrun_d;
         byte_ready_q <= byte_ready_d;
      end
   end

   assign raw_mfm    = cell_sr_q[15];
   assign busy       = (state_q == ACTIVE);
   assign underrun   = underrun_q;
   assign byte_ready = byte_ready_q;

endmodule

// File: tb/tb_mfm_encoder.sv
// Bench for mfm_encoder: drives bytes on negedges, captures cells while busy, and scores them
// against a bit-serial MFM model (clock pulse only between two zero data bits).
module tb_mfm_encoder;

   logic       clk_10 = 1'b0;
   logic       reset;
   logic [7:0] byte_in;
   logic       sync_req;
   logic       byte_valid;
   logic       byte_ready;
   logic       tx_en;
   logic       raw_mfm;
   logic       busy;
   logic       underrun;

   always #50 clk_10 = ~clk_10;

   mfm_encoder dut (
      .clk_10     (clk_10),
      .reset      (reset),
      .byte_in    (byte_in),
      .sync_req   (sync_req),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .tx_en      (tx_en),
      .raw_mfm    (raw_mfm),
      .busy       (busy),
      .underrun   (underrun)
   );

   typedef struct packed {
      logic       sync;
      logic [7:0] b;
   } item_t;

   item_t       tx_q[$];
   item_t       src_q[$];
   logic        cap_q[$];
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   int          ur_pos[$];
   int          acc_cyc[$];
   int          ur_cnt  = 0;
   int          idle_hi = 0;
   int          cyc     = 0;
   int          cmp_n   = 0;
   int          err_n   = 0;

   always @(posedge clk_10) cyc = cyc + 1;

   always @(negedge clk_10) begin
      if (!reset) begin
         if (underrun) begin
            ur_cnt++;
            ur_pos.push_back(cap_q.size());
         end
         if (busy) cap_q.push_back(raw_mfm);
         else if (raw_mfm) idle_hi++;
      end
   end

   function automatic item_t mk(input logic s, input logic [7:0] b);
      item_t it;
      it.sync = s;
      it.b    = b;
      return it;
   endfunction

   // Reference: walk the data bits; a clock pulse precedes a 0 that follows a 0.
   function automatic logic [15:0] ref_word(input logic [7:0] b, input bit prev);
      logic [15:0] w;
      bit          last;
      w    = 16'h0000;
      last = prev;
      for (int k = 7; k >= 0; k--) begin
         w    = {w[13:0], (!last && !b[k]), b[k]};
         last = b[k];
      end
      return w;
   endfunction

   function automatic void build_exp();
      bit prev;
      prev = 1'b0;
      exp_q.delete();
      foreach (src_q[i]) begin
         if (src_q[i].sync) begin
            exp_q.push_back(16'h4489);
            prev = 1'b1;
         end else begin
            exp_q.push_back(ref_word(src_q[i].b, prev));
            prev = src_q[i].b[0];
         end
      end
   endfunction

   function automatic void pack_cap();
      logic [15:0] w;
      got_q.delete();
      for (int i = 0; i + 16 <= cap_q.size(); i += 16) begin
         w = 16'h0000;
         for (int j = 0; j < 16; j++) w = {w[14:0], cap_q[i+j]};
         got_q.push_back(w);
      end
   endfunction

   function automatic void clear_capture();
      cap_q.delete();
      ur_pos.delete();
      acc_cyc.delete();
      ur_cnt = 0;
   endfunction

   task automatic offer(input item_t it, output bit ok);
      int g;
      g  = 0;
      ok = 1'b0;
      while (!ok && g < 400) begin
         @(negedge clk_10);
         g++;
         byte_in    = it.b;
         sync_req   = it.sync;
         byte_valid = 1'b1;
         if (byte_ready) begin
            ok = 1'b1;
            acc_cyc.push_back(cyc + 1);
         end
      end
   endtask

   task automatic drain(output bit ok);
      int g;
      g = 0;
      @(negedge clk_10);
      byte_valid = 1'b0;
      sync_req   = 1'b0;
      while (!byte_ready && g < 400) begin @(negedge clk_10); g++; end
      tx_en = 1'b0;
      while (busy && g < 400) begin @(negedge clk_10); g++; end
      ok = (g < 400);
   endtask

   task automatic run_stream(output bit ok);
      item_t it;
      bit    o;
      ok    = 1'b1;
      tx_en = 1'b1;
      while (tx_q.size() > 0) begin
         it = tx_q.pop_front();
         offer(it, o);
         if (!o) begin ok = 1'b0; tx_q.delete(); end
      end
      drain(o);
      if (!o) ok = 1'b0;
   endtask

   task automatic test_reset();
      bit o;
      int g;
      repeat (3) @(negedge clk_10);
      cmp_n++; if (raw_mfm !== 1'b0)    begin err_n++; $display("FAIL reset_raw: got %b want 0", raw_mfm); end
      cmp_n++; if (busy !== 1'b0)       begin err_n++; $display("FAIL reset_busy: got %b want 0", busy); end
      cmp_n++; if (byte_ready !== 1'b0) begin err_n++; $display("FAIL reset_ready: got %b want 0", byte_ready); end
      cmp_n++; if (underrun !== 1'b0)   begin err_n++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      reset = 1'b0;
      @(negedge clk_10);
      cmp_n++; if (byte_ready !== 1'b1) begin err_n++; $display("FAIL ready_after_reset: got %b want 1", byte_ready); end

      // Start a 0x00 word, queue another byte, then reset while a 1 cell is on the line.
      tx_en = 1'b1;
      offer(mk(1'b0, 8'h00), o);
      @(negedge clk_10);
      byte_valid = 1'b0;
      g = 0;
      while (!byte_ready && g < 100) begin @(negedge clk_10); g++; end
      offer(mk(1'b0, 8'($urandom)), o);
      @(negedge clk_10);
      byte_valid = 1'b0;
      repeat (2) @(negedge clk_10);
      cmp_n++; if (raw_mfm !== 1'b1 || !o) begin err_n++; $display("FAIL pre_reset_cell: got raw=%b acc=%b want 1", raw_mfm, o); end
      #20 reset = 1'b1;
      #1;
      cmp_n++; if (raw_mfm !== 1'b0)    begin err_n++; $display("FAIL midword_raw: got %b want 0", raw_mfm); end
      cmp_n++; if (busy !== 1'b0)       begin err_n++; $display("FAIL midword_busy: got %b want 0", busy); end
      cmp_n++; if (byte_ready !== 1'b0) begin err_n++; $display("FAIL midword_ready: got %b want 0", byte_ready); end
      cmp_n++; if (underrun !== 1'b0)   begin err_n++; $display("FAIL midword_underrun: got %b want 0", underrun); end
      @(negedge clk_10);
      reset = 1'b0;
      clear_capture();
      @(negedge clk_10);
      cmp_n++; if (byte_ready !== 1'b1) begin err_n++; $display("FAIL ready_after_midreset: got %b want 1", byte_ready); end
      repeat (20) @(negedge clk_10);
      cmp_n++; if (busy !== 1'b0 || cap_q.size() != 0) begin err_n++; $display("FAIL pending_discarded: got busy=%b cells=%0d want 0/0", busy, cap_q.size()); end
      tx_en = 1'b0;
   endtask

   task automatic test_single_bytes();
      bit          o;
      logic [15:0] want[3];
      logic [15:0] got;
      want[0] = 16'hAAAA; want[1] = 16'h5555; want[2] = 16'h2AAA;
      clear_capture();
      tx_en = 1'b1;
      offer(mk(1'b0, 8'h00), o);
      @(negedge clk_10);
      byte_valid = 1'b0;
      cmp_n++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin err_n++; $display("FAIL accept_cycle: got busy=%b ready=%b want 0/0", busy, byte_ready); end
      @(negedge clk_10);
      cmp_n++; if (busy !== 1'b1 || raw_mfm !== 1'b1 || byte_ready !== 1'b1) begin err_n++; $display("FAIL idle_latency: got busy=%b raw=%b ready=%b want 1/1/1", busy, raw_mfm, byte_ready); end
      tx_q.delete();
      tx_q.push_back(mk(1'b0, 8'hFF));
      tx_q.push_back(mk(1'b0, 8'h00));
      run_stream(o);
      cmp_n++; if (!o || cap_q.size() != 48) begin err_n++; $display("FAIL single_len: got %0d cells ok=%b want 48", cap_q.size(), o); end
      pack_cap();
      for (int i = 0; i < 3; i++) begin
         got = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
         cmp_n++; if (got !== want[i]) begin err_n++; $display("FAIL single_word%0d: got %h want %h", i, got, want[i]); end
      end
   endtask

   task automatic test_sync();
      bit o;
      clear_capture();
      tx_q.delete();
      tx_q.push_back(mk(1'b1, 8'($urandom)));
      tx_q.push_back(mk(1'b0, 8'hFE));
      run_stream(o);
      pack_cap();
      cmp_n++; if (!o || cap_q.size() != 32) begin err_n++; $display("FAIL sync_len: got %0d cells ok=%b want 32", cap_q.size(), o); end
      cmp_n++; if (got_q.size() < 1 || got_q[0] !== 16'h4489) begin err_n++; $display("FAIL sync_mark: got %h want 4489", (got_q.size() > 0) ? got_q[0] : 16'hxxxx); end
      cmp_n++; if (got_q.size() < 2 || got_q[1] !== 16'h5554) begin err_n++; $display("FAIL sync_next: got %h want 5554", (got_q.size() > 1) ? got_q[1] : 16'hxxxx); end
   endtask

   task automatic test_underrun();
      bit          o;
      int          g;
      logic [15:0] got;
      clear_capture();
      tx_en = 1'b1;
      offer(mk(1'b0, 8'h4E), o);
      @(negedge clk_10);
      byte_valid = 1'b0;
      g = 0;
      while (!byte_ready && g < 100) begin @(negedge clk_10); g++; end
      repeat (40) @(negedge clk_10);
      tx_en = 1'b0;
      while (busy && g < 200) begin @(negedge clk_10); g++; end
      cmp_n++; if (!o || g >= 200 || cap_q.size() != 48) begin err_n++; $display("FAIL underrun_len: got %0d cells want 48", cap_q.size()); end
      pack_cap();
      src_q.delete();
      repeat (3) src_q.push_back(mk(1'b0, 8'h4E));
      build_exp();
      got = (got_q.size() > 0) ? got_q[0] : 16'hxxxx;
      cmp_n++; if (got !== 16'h9254) begin err_n++; $display("FAIL underrun_first: got %h want 9254", got); end
      for (int i = 1; i < 3; i++) begin
         got = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
         cmp_n++; if (got !== exp_q[i]) begin err_n++; $display("FAIL gap_word%0d: got %h want %h", i, got, exp_q[i]); end
      end
      cmp_n++; if (ur_cnt != 2) begin err_n++; $display("FAIL underrun_count: got %0d want 2", ur_cnt); end
      cmp_n++; if (ur_pos.size() != 2 || ur_pos[0] != 16 || ur_pos[1] != 32) begin err_n++; $display("FAIL underrun_pos: got %0d pulses first at %0d want 16,32", ur_pos.size(), (ur_pos.size() > 0) ? ur_pos[0] : -1); end
   endtask

   task automatic test_write_gate();
      bit          o1, o2;
      int          g;
      logic [7:0]  x, y;
      logic [15:0] got;
      x = 8'($urandom) | 8'h01;
      y = 8'($urandom) & 8'h7F;
      clear_capture();
      tx_en = 1'b1;
      offer(mk(1'b0, x), o1);
      @(negedge clk_10);
      byte_valid = 1'b0;
      g = 0;
      while (!byte_ready && g < 100) begin @(negedge clk_10); g++; end
      repeat (3) @(negedge clk_10);
      tx_en = 1'b0;
      offer(mk(1'b0, y), o2);
      @(negedge clk_10);
      byte_valid = 1'b0;
      while (busy && g < 200) begin @(negedge clk_10); g++; end
      repeat (5) @(negedge clk_10);
      cmp_n++; if (!o1 || !o2 || cap_q.size() != 16) begin err_n++; $display("FAIL gate_complete: got %0d cells want 16", cap_q.size()); end
      cmp_n++; if (busy !== 1'b0 || byte_ready !== 1'b0 || raw_mfm !== 1'b0) begin err_n++; $display("FAIL gate_held: got busy=%b ready=%b raw=%b want 0/0/0", busy, byte_ready, raw_mfm); end
      tx_en = 1'b1;
      @(negedge clk_10);
      tx_en = 1'b0;
      cmp_n++; if (busy !== 1'b1) begin err_n++; $display("FAIL gate_resume: got busy=%b want 1", busy); end
      while (busy && g < 300) begin @(negedge clk_10); g++; end
      pack_cap();
      cmp_n++; if (cap_q.size() != 32) begin err_n++; $display("FAIL gate_len: got %0d cells want 32", cap_q.size()); end
      got = (got_q.size() > 0) ? got_q[0] : 16'hxxxx;
      cmp_n++; if (got !== ref_word(x, 1'b0)) begin err_n++; $display("FAIL gate_word0: got %h want %h", got, ref_word(x, 1'b0)); end
      got = (got_q.size() > 1) ? got_q[1] : 16'hxxxx;
      cmp_n++; if (got !== ref_word(y, 1'b0)) begin err_n++; $display("FAIL gate_word1_prev0: got %h want %h", got, ref_word(y, 1'b0)); end
   endtask

   task automatic test_back_to_back();
      bit          o;
      int          bad;
      logic [7:0]  start;
      logic [15:0] got;
      start = 8'($urandom);
      clear_capture();
      src_q.delete();
      for (int i = 0; i < 256; i++) src_q.push_back(mk(1'b0, 8'(start + 8'(i))));
      tx_q = src_q;
      build_exp();
      run_stream(o);
      pack_cap();
      cmp_n++; if (!o || cap_q.size() != 256*16) begin err_n++; $display("FAIL b2b_len: got %0d cells want %0d", cap_q.size(), 256*16); end
      cmp_n++; if (acc_cyc.size() != 256) begin err_n++; $display("FAIL b2b_accepts: got %0d want 256", acc_cyc.size()); end
      bad = 0;
      for (int i = 1; i < acc_cyc.size(); i++)
         if (acc_cyc[i] - acc_cyc[i-1] != ((i == 1) ? 2 : 16)) bad++;
      cmp_n++; if (bad != 0) begin err_n++; $display("FAIL b2b_spacing: got %0d bad accept gaps want 0", bad); end
      for (int i = 0; i < 256; i++) begin
         got = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
         cmp_n++; if (got !== exp_q[i]) begin err_n++; $display("FAIL b2b_word%0d: got %h want %h", i, got, exp_q[i]); end
      end
   endtask

   task automatic test_random();
      bit          o;
      logic [15:0] got;
      clear_capture();
      src_q.delete();
      for (int i = 0; i < 40; i++) src_q.push_back(mk(($urandom_range(0, 5) == 0), 8'($urandom)));
      tx_q = src_q;
      build_exp();
      run_stream(o);
      pack_cap();
      cmp_n++; if (!o || cap_q.size() != 40*16) begin err_n++; $display("FAIL rand_len: got %0d cells want %0d", cap_q.size(), 40*16); end
      for (int i = 0; i < 40; i++) begin
         got = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
         cmp_n++; if (got !== exp_q[i]) begin err_n++; $display("FAIL rand_word%0d: got %h want %h", i, got, exp_q[i]); end
      end
      cmp_n++; if (idle_hi != 0) begin err_n++; $display("FAIL idle_line: got %0d high idle cells want 0", idle_hi); end
   endtask

   initial begin
      reset      = 1'b1;
      byte_in    = 8'h00;
      sync_req   = 1'b0;
      byte_valid = 1'b0;
      tx_en      = 1'b0;
      test_reset();
      test_single_bytes();
      test_sync();
      test_underrun();
      test_write_gate();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
